imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port 8-bit instruction memory between the core fetch path (ifetch
//  inst_addr/inst_i) and the program loader (boot/debug write/readback port). Sequences each
//  access through the fixed memory read latency and returns data with a one-cycle valid pulse.
//  The ctrl unit qualifies ifetch_en with core_rvalid. Sits between ifetch/ctrl, loader and imem.
// PARAMETERS
//  MEM_LAT   1   imem read latency in cycles, legal 1..4 (rdata valid MEM_LAT cycles after issue)
//  MAX_WAIT  8   max cycles a pending core request may lose to the loader before forced grant
//  AW        12  address width (matches PC width)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset_       in   1   asynchronous active-low reset
//  core_req     in   1   core wants the byte at core_addr; held until core_rvalid
//  core_addr    in   AW  fetch address (ifetch inst_addr)
//  core_rvalid  out  1   1-cycle pulse: core_rdata valid; ctrl raises ifetch_en this cycle
//  core_rdata   out  8   fetched byte (to ifetch inst_i)
//  ld_req       in   1   loader access request; held with ld_we/addr/wdata until ld_ack
//  ld_we        in   1   1 = write, 0 = readback
//  ld_addr      in   AW  loader address
//  ld_wdata     in   8   loader write data
//  ld_ack       out  1   1-cycle pulse: loader access complete (ld_rdata valid if read)
//  ld_rdata     out  8   readback byte
//  mem_en       out  1   imem access strobe, 1 cycle per access
//  mem_we       out  1   imem write enable (only with mem_en)
//  mem_addr     out  AW  imem address
//  mem_wdata    out  8   imem write data
//  mem_rdata    in   8   imem read data, valid MEM_LAT cycles after mem_en
//  core_stalled out  1   core_req pending and not granted this cycle (perf/debug)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-access): state IDLE, lat_cnt=0, wait_cnt=0; all outputs 0;
//    in-flight access abandoned, no rvalid/ack issued for it.
//  - FSM: IDLE -> ISSUE_CORE | ISSUE_LD (registered grant) -> WAIT (lat_cnt counts MEM_LAT-1..0)
//    -> DONE (pulse rvalid/ack) -> IDLE. mem_en/we/addr/wdata driven from registers in ISSUE
//    only; zero otherwise. Latency req->valid = MEM_LAT+2 cycles; one access in flight.
//  - Arbitration in IDLE: loader wins over core, except when wait_cnt==MAX_WAIT core wins.
//    wait_cnt increments each IDLE cycle core_req=1 and loader granted; clears on core grant
//    or core_req=0; saturates at MAX_WAIT.
//  - Simultaneous core_req and ld_req with wait_cnt<MAX_WAIT: loader granted, wait_cnt+1.
//  - Loader write: mem_we=1 in ISSUE; ld_ack still pulses in DONE (uniform timing);
//    ld_rdata holds previous value on writes.
//  - Request dropped before completion: access finishes, pulse still issued, ignored by source.
//  - core_rdata/ld_rdata: captured from mem_rdata in DONE, held until next capture; 0 at reset.
//  - Request inputs sampled at grant only; changes after grant ignored until DONE.
//  - Address wrap is imem's concern; arbiter passes AW bits unchanged.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, ISSUE_CORE, ISSUE_LD, WAIT, DONE),
//    requester-id constants CORE/LD.
//  - Sub-module: imem_lat_timer (loadable down-counter, done flag) used for WAIT; rest flat.
// TESTING
//  - core_req only, addr 0x000..0x003, MEM_LAT=1 -> rvalid every 4 cycles, rdata = mem[addr].
//  - ld write 0xA5 @0x010 then ld read @0x010 -> ld_ack twice, ld_rdata=0xA5, mem_we only on 1st.
//  - core_req + ld_req held continuously, MAX_WAIT=8 -> 8 loader grants then 1 core grant, repeat.
//  - reset_ low during WAIT of a core read -> outputs 0 async, no rvalid; fresh fetch after release.
//  - MEM_LAT=4 sweep -> req-to-rvalid exactly 6 cycles; mem_en single-cycle per access.
//  - ld_req dropped 1 cycle after grant -> ld_ack still pulses once, no second mem_en.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encoding,
// requester identifiers and the latency-timer width.
package imem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_CORE,
        ISSUE_LD,
        WAIT,
        DONE
    } state_t;

    typedef logic req_id_t;
    localparam req_id_t CORE = 1'b0;
    localparam req_id_t LD   = 1'b1;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 4
    localparam int LAT_W = 3;

endpackage

// File: rtl/imem_arbiter_lat_timer.sv
// Loadable down-counter that paces the WAIT state through the imem read latency.
module imem_lat_timer
    import imem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_,
    input  logic             load,
    input  logic             en,
    input  logic [LAT_W-1:0] load_val,
    output logic             done
);

    logic [LAT_W-1:0] lat_cnt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            lat_cnt <= '0;
        end else if (load) begin
            lat_cnt <= load_val;
        end else if (en && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    assign done = (lat_cnt == '0);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between core fetch and the program
// loader; one access in flight, result returned with a single-cycle pulse.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 8,
    parameter int AW       = 12
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    output logic          core_rvalid,
    output logic [7:0]    core_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_wdata,
    output logic          ld_ack,
    output logic [7:0]    ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          core_stalled
);

    localparam int               WC_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0]  WAIT_MAX = WC_W'(MAX_WAIT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    state_t          state;
    state_t          state_nxt;
    req_id_t         gnt_id;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      wdata_q;
    logic [WC_W-1:0] wait_cnt;
    logic            core_win;
    logic            ld_win;
    logic            issue;
    logic            lat_done;

    // Loader has priority until the core has been passed over MAX_WAIT times
    always_comb begin
        core_win = 1'b0;
        ld_win   = 1'b0;
        if (state == IDLE) begin
            if (core_req && (wait_cnt == WAIT_MAX)) begin
                core_win = 1'b1;
            end else if (ld_req) begin
                ld_win = 1'b1;
            end else if (core_req) begin
                core_win = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        core_rvalid  = 1'b0;
        ld_ack       = 1'b0;
        core_stalled = core_req && !core_win && !((state != IDLE) && (gnt_id == CORE));
        unique case (state)
            IDLE: begin
                if (core_win) begin
                    state_nxt = ISSUE_CORE;
                end else if (ld_win) begin
                    state_nxt = ISSUE_LD;
                end
            end
            ISSUE_CORE, ISSUE_LD: begin
                state_nxt = WAIT;
                issue     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            WAIT: begin
                if (lat_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                core_rvalid = (gnt_id == CORE);
                ld_ack      = (gnt_id == LD);
            end
            default: state_nxt = IDLE;
        endcase
    end

    imem_lat_timer u_lat_timer (
        .clk      (clk),
        .reset_   (reset_),
        .load     (issue),
        .en       (state == WAIT),
        .load_val (LAT_LOAD),
        .done     (lat_done)
    );

    // Request fields are latched only at grant; later input changes are ignored
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            gnt_id     <= CORE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            core_rdata <= '0;
            ld_rdata   <= '0;
        end else begin
            if (core_win) begin
                gnt_id  <= CORE;
                we_q    <= 1'b0;
                addr_q  <= core_addr;
                wdata_q <= '0;
            end else if (ld_win) begin
                gnt_id  <= LD;
                we_q    <= ld_we;
                addr_q  <= ld_addr;
                wdata_q <= ld_wdata;
            end

            if (!core_req || core_win) begin
                wait_cnt <= '0;
            end else if (ld_win && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // Read data is on mem_rdata during the last WAIT cycle
            if ((state == WAIT) && lat_done) begin
                if (gnt_id == CORE) begin
                    core_rdata <= mem_rdata;
                end else if (!we_q) begin
                    ld_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
